layer_param_mem: RTL and testbench
==================================

Name: layer_param_mem

Overview:
- Programmable parameter store for one fully connected layer. Holds N_NEURONS×N_INPUTS signed weights and N_NEURONS signed biases.
- Weights and biases are loaded serially, one word per beat.
- The store is then read as a valid/ready stream of LANES weights per beat, neuron by neuron.
- It feeds the neuron MAC datapath and replaces fixed-constant parameter blocks, so a layer can be reprogrammed without resynthesis.

Parameters:
- N_NEURONS, 30, number of neurons (rows).
- N_INPUTS, 784, inputs per neuron (columns). Must be a multiple of LANES; elaboration fails otherwise.
- W_WIDTH, 8, bit width of each signed weight/bias word.
- LANES, 4, weights emitted per stream beat.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; starts a full load (honoured in IDLE only).
- load_valid  in  1  load word present.
- load_data  in  W_WIDTH  signed load word.
- load_ready  out  1  high in LOAD; a word transfers when load_valid&&load_ready.
- load_done  out  1  one-cycle pulse after the final word is written.
- rd_start  in  1  one-cycle pulse; starts streaming (honoured in IDLE and only when loaded=1).
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_weights  out  LANES*W_WIDTH  lane k in bits [k*W_WIDTH +: W_WIDTH] holds weight index beat*LANES+k.
- out_bias  out  W_WIDTH  bias of the current neuron, constant across all its beats.
- out_neuron  out  $clog2(N_NEURONS)  current neuron index.
- out_last  out  1  marks the last beat of the current neuron.
- stream_done  out  1  one-cycle pulse after the final beat of the final neuron is accepted.
- busy  out  1  high when state≠IDLE.
- loaded  out  1  high when a complete load has finished since reset.

Behaviour:
- Reset (async): state=IDLE; all counters=0; loaded=0; load_ready, load_done, out_valid, stream_done and busy are all 0; out_weights, out_bias, out_neuron and out_last are 0. Weight/bias storage is not reset (contents undefined).
- States: IDLE, LOAD, STREAM.
- IDLE→LOAD on load_start. IDLE→STREAM on rd_start && loaded. If both pulse in the same cycle, load_start wins.
- In LOAD or STREAM, load_start and rd_start are ignored.
- LOAD word order, per neuron n=0..N_NEURONS-1: weights j=0..N_INPUTS-1, then the bias.
  - Total words: N_NEURONS*(N_INPUTS+1).
  - Weight j is written to bank j%LANES at row n*(N_INPUTS/LANES)+j/LANES.
  - Biases go to a separate register array.
  - Stalls on load_valid=0 are unlimited.
  - The final transfer returns the state to IDLE, sets loaded=1 and pulses load_done in the next cycle.
- A new load clears loaded on entry to LOAD. If reset interrupts a load, loaded=0.
- STREAM uses 1-cycle synchronous bank reads.
  - The first out_valid is asserted exactly 2 cycles after the rd_start cycle.
  - With out_ready held high, beats issue at one per cycle with no bubbles.
  - Total beats: N_NEURONS*N_INPUTS/LANES.
- Handshake: a beat transfers on out_valid&&out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals hold stable.
  - out_valid never drops without a transfer.
  - Prefetch/skid buffering is internal.
- out_last=1 on beat N_INPUTS/LANES-1 of each neuron. out_neuron increments after an out_last transfer and wraps to 0 only at end of stream.
- On transfer of the final beat: out_valid=0 next cycle, stream_done pulses, state returns to IDLE. A further rd_start replays identical data.
- Reset mid-stream: output is dropped immediately and the block returns to IDLE with loaded=0.
- Data is stored and emitted unmodified; there is no sign extension or arithmetic.

Test Plan:
Parameters for all scenarios: N_NEURONS=3, N_INPUTS=8, LANES=4, W_WIDTH=8.
1. Load words v=0..26, where neuron n weight j = n*9+j and bias = n*9+8, with load_valid held high. Expect load_ready high for 27 cycles, load_done pulse, then loaded=1. Then rd_start with out_ready=1:
   - out_valid rises 2 cycles after rd_start.
   - 6 consecutive beats; beat0 out_weights lanes = {0,1,2,3}, out_bias=8, out_neuron=0; beat1 = {4,5,6,7} with out_last=1.
   - beat5 = {22,23,24,25}, out_bias=26, out_neuron=2.
   - stream_done pulses once.
2. During the stream, drive out_ready with pattern 1,0,0,1,0,1,... Expect identical 6-beat sequence, outputs stable during every stall, no beat lost or duplicated.
3. Load with load_valid toggling randomly, including negative words 8'sh80 and 8'shFF. Expect the stream to reproduce them bit-exact.
4. Pulse rd_start before any load. Expect no out_valid and busy=0. Pulse load_start and rd_start together. Expect state LOAD.
5. Pulse rd_start during LOAD and load_start during STREAM. Expect both ignored, and current-operation word/beat counts unchanged.
6. Assert rst on beat 3 of a stream. Expect out_valid=0, busy=0 and loaded=0 immediately; a subsequent reload and stream matches scenario 1.

Source files
------------

// File: rtl/layer_param_mem.sv
// Programmable weight/bias store for one fully connected layer: serial load,
// LANES-wide valid/ready read stream neuron by neuron.
module layer_param_mem #(
  parameter int unsigned N_NEURONS = 30,
  parameter int unsigned N_INPUTS  = 784,
  parameter int unsigned W_WIDTH   = 8,
  parameter int unsigned LANES     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_start,
  input  logic                          load_valid,
  input  logic [W_WIDTH-1:0]            load_data,
  output logic                          load_ready,
  output logic                          load_done,
  input  logic                          rd_start,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*W_WIDTH-1:0]      out_weights,
  output logic [W_WIDTH-1:0]            out_bias,
  output logic [$clog2(N_NEURONS)-1:0]  out_neuron,
  output logic                          out_last,
  output logic                          stream_done,
  output logic                          busy,
  output logic                          loaded
);
  localparam int unsigned BPN  = N_INPUTS / LANES;
  localparam int unsigned ROWS = N_NEURONS * BPN;
  localparam int unsigned NW   = $clog2(N_NEURONS);
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW   = (BPN > 1) ? $clog2(BPN) : 1;
  localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1;

  if (N_INPUTS % LANES != 0) begin : g_lanes_check
    $error("layer_param_mem: N_INPUTS must be a multiple of LANES");
  end

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

  state_t state, state_d;

  logic [W_WIDTH-1:0] bank     [LANES][ROWS];
  logic [W_WIDTH-1:0] bias_mem [N_NEURONS];

  logic [LW-1:0] ld_lane;
  logic [RW-1:0] ld_row;
  logic [BW-1:0] ld_beat;
  logic [NW-1:0] ld_neuron;
  logic          ld_bias;

  logic [RW-1:0] rd_row;
  logic [BW-1:0] rd_beat;
  logic [NW-1:0] rd_neuron;
  logic          rd_all;

  logic ld_enter, st_enter, ld_fire, ld_final, rd_issue, out_xfer, st_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // load_ready is high exactly while in LOAD, so load_valid alone qualifies a word there
  always_comb begin
    state_d  = state;
    ld_enter = 1'b0;
    st_enter = 1'b0;
    ld_fire  = 1'b0;
    ld_final = 1'b0;
    rd_issue = 1'b0;
    out_xfer = 1'b0;
    st_final = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_d  = LOAD;
          ld_enter = 1'b1;
        end else if (rd_start && loaded) begin
          state_d  = STREAM;
          st_enter = 1'b1;
        end
      end
      LOAD: begin
        ld_fire  = load_valid;
        ld_final = load_valid && ld_bias && (ld_neuron == NW'(N_NEURONS - 1));
        if (ld_final) state_d = IDLE;
      end
      STREAM: begin
        out_xfer = out_valid && out_ready;
        rd_issue = !rd_all && (!out_valid || out_ready);
        st_final = out_xfer && rd_all;
        if (st_final) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Parameter storage; deliberately not reset
  always_ff @(posedge clk) begin
    if (ld_fire && !ld_bias) bank[ld_lane][ld_row] <= load_data;
    if (ld_fire && ld_bias)  bias_mem[ld_neuron]   <= load_data;
  end

  // Load write pointer: lane/row walk for weights, then one bias per neuron
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_lane   <= '0;
      ld_row    <= '0;
      ld_beat   <= '0;
      ld_neuron <= '0;
      ld_bias   <= 1'b0;
    end else if (ld_enter) begin
      ld_lane   <= '0;
      ld_row    <= '0;
      ld_beat   <= '0;
      ld_neuron <= '0;
      ld_bias   <= 1'b0;
    end else if (ld_fire) begin
      if (ld_bias) begin
        ld_bias   <= 1'b0;
        ld_neuron <= ld_neuron + 1'b1;
      end else if (ld_lane == LW'(LANES - 1)) begin
        ld_lane <= '0;
        ld_row  <= ld_row + 1'b1;
        if (ld_beat == BW'(BPN - 1)) begin
          ld_beat <= '0;
          ld_bias <= 1'b1;
        end else begin
          ld_beat <= ld_beat + 1'b1;
        end
      end else begin
        ld_lane <= ld_lane + 1'b1;
      end
    end
  end

  // Bank read registers double as the output stage; a read only fires when the slot frees
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_row      <= '0;
      rd_beat     <= '0;
      rd_neuron   <= '0;
      rd_all      <= 1'b0;
      out_valid   <= 1'b0;
      out_weights <= '0;
      out_bias    <= '0;
      out_neuron  <= '0;
      out_last    <= 1'b0;
    end else begin
      if (st_enter) begin
        rd_row    <= '0;
        rd_beat   <= '0;
        rd_neuron <= '0;
        rd_all    <= 1'b0;
      end
      if (rd_issue) begin
        out_valid <= 1'b1;
        for (int k = 0; k < LANES; k++) begin
          out_weights[k*W_WIDTH +: W_WIDTH] <= bank[k][rd_row];
        end
        out_bias   <= bias_mem[rd_neuron];
        out_neuron <= rd_neuron;
        out_last   <= (rd_beat == BW'(BPN - 1));
        rd_row     <= rd_row + 1'b1;
        if (rd_beat == BW'(BPN - 1)) begin
          rd_beat <= '0;
          if (rd_neuron == NW'(N_NEURONS - 1)) rd_all <= 1'b1;
          else                                 rd_neuron <= rd_neuron + 1'b1;
        end else begin
          rd_beat <= rd_beat + 1'b1;
        end
      end else if (out_xfer) begin
        out_valid <= 1'b0;
        if (st_final) begin
          out_neuron <= '0;
          out_last   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      stream_done <= 1'b0;
      busy        <= 1'b0;
      loaded      <= 1'b0;
    end else begin
      load_ready  <= (state_d == LOAD);
      busy        <= (state_d != IDLE);
      load_done   <= ld_final;
      stream_done <= st_final;
      if (ld_enter)      loaded <= 1'b0;
      else if (ld_final) loaded <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_param_mem.sv
// Randomized self-checking bench for layer_param_mem against an array-based model.
module tb_layer_param_mem;
  localparam int NN     = 3;
  localparam int NI     = 8;
  localparam int WW     = 8;
  localparam int LN     = 4;
  localparam int BPN    = NI / LN;
  localparam int BEATS  = NN * BPN;
  localparam int NWORDS = NN * (NI + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_start = 1'b0;
  logic              load_valid = 1'b0;
  logic [WW-1:0]     load_data = '0;
  logic              load_ready;
  logic              load_done;
  logic              rd_start = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [LN*WW-1:0]  out_weights;
  logic [WW-1:0]     out_bias;
  logic [1:0]        out_neuron;
  logic              out_last;
  logic              stream_done;
  logic              busy;
  logic              loaded;

  layer_param_mem #(.N_NEURONS(NN), .N_INPUTS(NI), .W_WIDTH(WW), .LANES(LN)) dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done),
    .rd_start(rd_start), .out_valid(out_valid), .out_ready(out_ready),
    .out_weights(out_weights), .out_bias(out_bias), .out_neuron(out_neuron),
    .out_last(out_last), .stream_done(stream_done), .busy(busy), .loaded(loaded)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [WW-1:0] words [NWORDS];
  logic [WW-1:0] mw [NN][NI];
  logic [WW-1:0] mb [NN];
  int exp_idx  = 0;
  int done_cnt = 0;
  bit pin = 1'b0;
  bit prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: word v belongs to neuron v/(NI+1); its first NI slots are weights, the last the bias
  task automatic set_model();
    for (int v = 0; v < NWORDS; v++) begin
      if ((v % (NI + 1)) < NI) mw[v / (NI + 1)][v % (NI + 1)] = words[v];
      else                     mb[v / (NI + 1)] = words[v];
    end
  endtask

  function automatic logic [LN*WW-1:0] exp_w(input int b);
    logic [LN*WW-1:0] r;
    r = '0;
    for (int k = 0; k < LN; k++) r[k*WW +: WW] = mw[b / BPN][(b % BPN) * LN + k];
    return r;
  endfunction

  function automatic logic rdy(input int mode, input int c);
    logic [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[(c + 4) % 6];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Compare process: every beat on the bus must match the model at the current stream index
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (exp_idx >= BEATS) begin
          chk("extra_beat", 64'(exp_idx), 64'(BEATS - 1));
        end else begin
          chk("beat_weights", 64'(out_weights), 64'(exp_w(exp_idx)));
          chk("beat_bias", 64'(out_bias), 64'(mb[exp_idx / BPN]));
          chk("beat_neuron", 64'(out_neuron), 64'(exp_idx / BPN));
          chk("beat_last", 64'(out_last), 64'((exp_idx % BPN) == BPN - 1));
          if (pin && exp_idx == 0) begin
            chk("pin_b0_weights", 64'(out_weights), 64'h03020100);
            chk("pin_b0_bias", 64'(out_bias), 64'd8);
          end
          if (pin && exp_idx == 1) begin
            chk("pin_b1_weights", 64'(out_weights), 64'h07060504);
            chk("pin_b1_last", 64'(out_last), 64'd1);
          end
          if (pin && exp_idx == 5) begin
            chk("pin_b5_weights", 64'(out_weights), 64'h19181716);
            chk("pin_b5_bias", 64'(out_bias), 64'd26);
            chk("pin_b5_neuron", 64'(out_neuron), 64'd2);
          end
        end
        if (out_ready) exp_idx++;
      end
      if (stream_done) begin
        done_cnt++;
        chk("done_valid_low", 64'(out_valid), 64'd0);
        chk("done_beats", 64'(exp_idx), 64'(BEATS));
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic run_load(input int valid_mode, input bit with_rd, input int rd_pulse_at);
    int idx;
    int cyc;
    int rdy_cycles;
    bit xfer;
    idx = 0;
    cyc = 0;
    rdy_cycles = 0;
    @(posedge clk); #1;
    load_start = 1'b1;
    rd_start   = with_rd;
    @(posedge clk); #1;
    load_start = 1'b0;
    rd_start   = 1'b0;
    load_valid = (valid_mode == 0) || ($urandom_range(0, 2) != 0);
    load_data  = words[0];
    while (idx < NWORDS && cyc < 1000) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("load_entry_ready", 64'(load_ready), 64'd1);
        chk("load_entry_busy", 64'(busy), 64'd1);
        chk("load_entry_loaded", 64'(loaded), 64'd0);
      end
      if (load_ready) rdy_cycles++;
      xfer = load_valid && load_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
      rd_start   = (cyc == rd_pulse_at);
      load_valid = (idx < NWORDS) && ((valid_mode == 0) || ($urandom_range(0, 2) != 0));
      load_data  = (idx < NWORDS) ? words[idx] : '0;
    end
    load_valid = 1'b0;
    rd_start   = 1'b0;
    @(negedge clk);
    chk("load_all_words", 64'(idx), 64'(NWORDS));
    chk("load_done_pulse", 64'(load_done), 64'd1);
    chk("loaded_set", 64'(loaded), 64'd1);
    chk("load_ready_low", 64'(load_ready), 64'd0);
    chk("busy_low_after_load", 64'(busy), 64'd0);
    if (valid_mode == 0) chk("load_ready_cycles", 64'(rdy_cycles), 64'(NWORDS));
    @(posedge clk); #1;
    @(negedge clk);
    chk("load_done_single", 64'(load_done), 64'd0);
    set_model();
  endtask

  task automatic run_stream(input int mode, input int load_pulse_at, input int rst_beat);
    int c;
    c = 0;
    exp_idx  = 0;
    done_cnt = 0;
    @(posedge clk); #1;
    rd_start  = 1'b1;
    out_ready = rdy(mode, 0);
    while (done_cnt == 0 && c < 300) begin
      @(negedge clk); #1;
      if (c == 1) chk("first_valid_early", 64'(out_valid), 64'd0);
      if (c == 2) chk("first_valid_t2", 64'(out_valid), 64'd1);
      if (done_cnt != 0) break;
      @(posedge clk); #1;
      c++;
      rd_start   = 1'b0;
      load_start = (c == load_pulse_at);
      out_ready  = rdy(mode, c);
      if (rst_beat >= 0 && exp_idx == rst_beat && out_valid) begin
        load_start = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_loaded", 64'(loaded), 64'd0);
        chk("rst_out_weights", 64'(out_weights), 64'd0);
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    load_start = 1'b0;
    chk("stream_done_seen", 64'(done_cnt), 64'd1);
    chk("busy_after_stream", 64'(busy), 64'd0);
    chk("load_ready_after_stream", 64'(load_ready), 64'd0);
    chk("loaded_after_stream", 64'(loaded), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("stream_done_single", 64'(stream_done), 64'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_load_ready", 64'(load_ready), 64'd0);
    chk("reset_load_done", 64'(load_done), 64'd0);
    chk("reset_stream_done", 64'(stream_done), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_loaded", 64'(loaded), 64'd0);
    chk("reset_out_weights", 64'(out_weights), 64'd0);
    chk("reset_out_bias", 64'(out_bias), 64'd0);
    chk("reset_out_neuron", 64'(out_neuron), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;

    // Read request with nothing loaded is ignored
    @(posedge clk); #1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("noload_out_valid", 64'(out_valid), 64'd0);
      chk("noload_busy", 64'(busy), 64'd0);
    end

    // Sequential words; load_start and rd_start together must pick LOAD
    for (int v = 0; v < NWORDS; v++) words[v] = WW'(v);
    run_load(0, 1'b1, -1);
    pin = 1'b1;
    run_stream(0, -1, -1);
    run_stream(1, -1, -1);
    run_stream(0, 4, -1);

    // Random words with extreme negative values, random valid gaps, rd_start mid-load
    for (int v = 0; v < NWORDS; v++) words[v] = WW'($urandom);
    words[0]  = 8'h80;
    words[3]  = 8'hFF;
    words[8]  = 8'h80;
    words[17] = 8'hFF;
    words[21] = 8'h80;
    words[26] = 8'hFF;
    pin = 1'b0;
    run_load(1, 1'b0, 5);
    run_stream(2, -1, -1);
    run_stream(2, -1, -1);

    // Reset mid-stream, then full reload and replay
    run_stream(0, -1, 3);
    chk("post_rst_loaded", 64'(loaded), 64'd0);
    for (int v = 0; v < NWORDS; v++) words[v] = WW'(v);
    run_load(0, 1'b0, -1);
    pin = 1'b1;
    run_stream(0, -1, -1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
